// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package rf_sched_pkg;

  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_AW = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_scheduler_reg_scoreboard.sv
// Busy bit per architectural register, tracking outstanding long-latency results.
module reg_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic [AW-1:0]     rd_addr,
  output logic [2**AW-1:0]  busy_vec,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy
);

  logic [2**AW-1:0] busy_q;
  logic [2**AW-1:0] busy_d;

  // Next busy bits: clear first so a same-register set wins; r0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read taps from the registered state only (no same-cycle bypass).
  always_comb begin
    busy_vec = busy_q;
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
    rd_busy  = busy_q[rd_addr];
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (pipeline WB vs long-latency unit) with
// starvation forcing and a busy scoreboard driving issue stalls.
module regfile_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned DW         = DEFAULT_DW,
  parameter int unsigned AW         = DEFAULT_AW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              iss_valid,
  input  logic              iss_use_rs1,
  input  logic              iss_use_rs2,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_long,
  output logic              iss_stall,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DW-1:0]     wb_data,
  output logic              wb_hold,
  input  logic              lu_valid,
  input  logic [AW-1:0]     lu_rd,
  input  logic [DW-1:0]     lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [2**AW-1:0]  busy_vec
);

  localparam logic [3:0]    STARVE_LAST = 4'(STARVE_MAX - 1);
  localparam logic [AW-1:0] ZERO_ADDR   = AW'(REG_ZERO);

  arb_state_e    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic wb_grant, lu_grant, iss_set;
  logic rs1_busy, rs2_busy, rd_busy;

  reg_scoreboard #(.AW(AW)) u_scoreboard (
    .clk      (CLK),
    .rst      (Reset),
    .set_en   (iss_set),
    .set_addr (iss_rd),
    .clr_en   (lu_grant),
    .clr_addr (lu_rd),
    .rs1_addr (iss_rs1),
    .rs2_addr (iss_rs2),
    .rd_addr  (iss_rd),
    .busy_vec (busy_vec),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Arbiter state, starvation counter and write-port registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ARB_NORMAL;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Next arbiter state and saturating count of consecutive LU denials.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_NORMAL: begin
        if (lu_valid && !lu_ready) begin
          if (starve_q == STARVE_LAST) begin
            state_d  = ARB_FORCE;
            starve_d = starve_q;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          starve_d = '0;
        end
      end
      ARB_FORCE: begin
        state_d  = ARB_NORMAL;
        starve_d = '0;
      end
    endcase
  end

  // Arbiter outputs: WB has priority except while forcing the LU through.
  always_comb begin
    wb_hold  = (state_q == ARB_FORCE);
    lu_ready = (state_q == ARB_FORCE) ? 1'b1 : !wb_valid;
  end

  // Grant decode and next write-port contents; r0 writes are granted but dropped.
  always_comb begin
    wb_grant   = wb_valid && !wb_hold;
    lu_grant   = lu_valid && lu_ready;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_grant) begin
      if (wb_rd != ZERO_ADDR) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_rd;
        rf_wdata_d = wb_data;
      end
    end else if (lu_grant) begin
      if (lu_rd != ZERO_ADDR) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = lu_rd;
        rf_wdata_d = lu_data;
      end
    end
  end

  // Issue hazard check (RAW on sources, WAW on rd) and scoreboard set.
  always_comb begin
    iss_stall = iss_valid && ((iss_use_rs1 && rs1_busy) ||
                              (iss_use_rs2 && rs2_busy) || rd_busy);
    iss_set   = iss_valid && iss_long && !iss_stall && (iss_rd != ZERO_ADDR);
  end

  // Registered write-port outputs.
  always_comb begin
    rf_we    = rf_we_q;
    rf_waddr = rf_waddr_q;
    rf_wdata = rf_wdata_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler (DW=32, AW=5, STARVE_MAX=4).
module tb_regfile_wb_scheduler;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        iss_valid, iss_use_rs1, iss_use_rs2, iss_long;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int unsigned checks = 0;
  int unsigned errors = 0;

  regfile_wb_scheduler #(.DW(32), .AW(5), .STARVE_MAX(4)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .iss_valid   (iss_valid),
    .iss_use_rs1 (iss_use_rs1),
    .iss_use_rs2 (iss_use_rs2),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_long    (iss_long),
    .iss_stall   (iss_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_hold     (wb_hold),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_vec    (busy_vec)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iss_valid = 0; iss_use_rs1 = 0; iss_use_rs2 = 0; iss_long = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Reset then idle
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_stall", iss_stall, 0);
    chk("rst_wb_hold", wb_hold, 0);
    chk("rst_lu_ready", lu_ready, 1);

    // Long-op issue to r5
    iss_valid = 1; iss_long = 1; iss_rd = 5;
    #1 chk("iss5_nostall", iss_stall, 0);
    tick();
    chk("busy5_set", busy_vec, 32'h0000_0020);

    // RAW on r5 stalls
    iss_long = 0; iss_use_rs1 = 1; iss_rs1 = 5; iss_rd = 6;
    #1 chk("raw_stall", iss_stall, 1);
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEAD_BEEF;
    #1 chk("lu_ready_idle", lu_ready, 1);
    chk("raw_stall_same_cycle", iss_stall, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("lu_wr_we", rf_we, 1);
    chk("lu_wr_addr", rf_waddr, 5);
    chk("lu_wr_data", rf_wdata, 32'hDEAD_BEEF);
    chk("busy5_clr", busy_vec, 0);
    chk("raw_release", iss_stall, 0);
    clear_inputs();
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_hold_addr", rf_waddr, 5);
    chk("idle_hold_data", rf_wdata, 32'hDEAD_BEEF);

    // Contention without starvation
    wb_valid = 1; wb_rd = 3; wb_data = 32'h0000_00A1;
    lu_valid = 1; lu_rd = 4; lu_data = 32'h0000_00B4;
    #1 chk("cont_lu_ready0", lu_ready, 0);
    chk("cont_wb_hold0", wb_hold, 0);
    tick();
    chk("cont_wb1_addr", rf_waddr, 3);
    chk("cont_wb1_data", rf_wdata, 32'h0000_00A1);
    wb_rd = 8; wb_data = 32'h0000_00A2;
    tick();
    chk("cont_wb2_we", rf_we, 1);
    chk("cont_wb2_addr", rf_waddr, 8);
    chk("cont_wb2_data", rf_wdata, 32'h0000_00A2);
    wb_valid = 0;
    #1 chk("cont_lu_ready1", lu_ready, 1);
    tick();
    lu_valid = 0;
    chk("cont_lu_we", rf_we, 1);
    chk("cont_lu_addr", rf_waddr, 4);
    chk("cont_lu_data", rf_wdata, 32'h0000_00B4);
    tick();

    // Starvation: four denials, then FORCE
    wb_valid = 1; wb_rd = 10; wb_data = 32'hC0DE_0001;
    lu_valid = 1; lu_rd = 7;  lu_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("starve_hold%0d", i), wb_hold, 0);
      chk($sformatf("starve_ready%0d", i), lu_ready, 0);
      tick();
      chk($sformatf("starve_wb_addr%0d", i), rf_waddr, 10);
    end
    chk("force_hold", wb_hold, 1);
    chk("force_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("force_lu_we", rf_we, 1);
    chk("force_lu_addr", rf_waddr, 7);
    chk("force_lu_data", rf_wdata, 32'h1234_5678);
    chk("after_force_hold", wb_hold, 0);
    chk("after_force_ready", lu_ready, 0);
    tick();
    chk("held_wb_we", rf_we, 1);
    chk("held_wb_addr", rf_waddr, 10);
    chk("held_wb_data", rf_wdata, 32'hC0DE_0001);
    clear_inputs();
    tick();

    // Register zero
    wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    tick();
    chk("r0_we", rf_we, 0);
    chk("r0_addr_hold", rf_waddr, 10);
    chk("r0_data_hold", rf_wdata, 32'hC0DE_0001);
    clear_inputs();
    iss_valid = 1; iss_long = 1; iss_rd = 0;
    #1 chk("r0_iss_nostall", iss_stall, 0);
    tick();
    chk("r0_busy", busy_vec, 0);

    // Same-cycle set and clear of r9: set wins
    iss_rd = 9;
    lu_valid = 1; lu_rd = 9; lu_data = 32'h0000_0099;
    #1 chk("r9_nostall", iss_stall, 0);
    tick();
    clear_inputs();
    #1;
    chk("r9_set_wins", busy_vec, 32'h0000_0200);
    chk("r9_lu_we", rf_we, 1);
    chk("r9_lu_addr", rf_waddr, 9);

    // WAW: any instruction targeting busy r9 stalls
    iss_valid = 1; iss_rd = 9;
    #1 chk("waw_stall", iss_stall, 1);
    clear_inputs();
    tick();

    // Reset while in FORCE, with r9 busy and a pending LU grant
    wb_valid = 1; wb_rd = 11; wb_data = 32'h0000_0011;
    lu_valid = 1; lu_rd = 9;  lu_data = 32'h0000_0077;
    tick(); tick(); tick(); tick();
    chk("pre_rst_force", wb_hold, 1);
    Reset = 1;
    tick();
    Reset = 0;
    #1;
    chk("rst_force_hold", wb_hold, 0);
    chk("rst_force_ready", lu_ready, 0);
    chk("rst_force_busy", busy_vec, 0);
    chk("rst_force_we", rf_we, 0);
    chk("rst_force_addr", rf_waddr, 0);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single register-file write port and the busy scoreboard for the five-stage pipeline.
- Arbitrates writes between two sources:
  - the in-order pipeline WB stage;
  - a multi-cycle long-latency unit (LU), such as a divider or slow load.
- Tracks registers with outstanding LU results and stalls issue on RAW or WAW hazards against them.
- Includes a starvation counter so the LU cannot be locked out of the write port indefinitely.

Parameters:
- DW, 32, data width of write port.
- AW, 5, register address width (2**AW registers).
- STARVE_MAX, 4, number of consecutive denied LU cycles before the LU is forced a grant (range 1..15).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- iss_valid  input  1  ID stage presents an instruction.
- iss_use_rs1  input  1  instruction reads rs1.
- iss_use_rs2  input  1  instruction reads rs2.
- iss_rs1  input  AW  source 1 address.
- iss_rs2  input  AW  source 2 address.
- iss_rd  input  AW  destination address.
- iss_long  input  1  instruction writes rd via the LU.
- iss_stall  output  1  hold ID; combinational.
- wb_valid  input  1  pipeline WB write request.
- wb_rd  input  AW  pipeline WB write address.
- wb_data  input  DW  pipeline WB write data.
- wb_hold  output  1  freeze the pipeline WB stage this cycle; combinational.
- lu_valid  input  1  LU result available.
- lu_rd  input  AW  LU write address.
- lu_data  input  DW  LU write data.
- lu_ready  output  1  LU result accepted this cycle; combinational.
- rf_we  output  1  register-file write enable; registered.
- rf_waddr  output  AW  register-file write address; registered.
- rf_wdata  output  DW  register-file write data; registered.
- busy_vec  output  2**AW  scoreboard bits, for debug and assertions; registered.

Behaviour:
- Reset (sync, synchronous to CLK, active-high):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0.
  - Arbiter state = NORMAL, starve_cnt = 0.
  - Reset overrides every same-cycle event, including mid-FORCE and a pending issue.
- Arbiter FSM, two states: NORMAL and FORCE.
  - NORMAL:
    - wb_hold = 0; lu_ready = !wb_valid.
    - Pipeline WB has priority.
    - starve_cnt increments when lu_valid && !lu_ready; otherwise starve_cnt = 0.
    - If lu_valid && !lu_ready && starve_cnt == STARVE_MAX-1, the next state is FORCE.
  - FORCE:
    - wb_hold = 1, lu_ready = 1.
    - The pipeline WB request is not written; the pipeline keeps wb_valid/wb_rd/wb_data stable while held.
    - On lu_valid: LU is granted, next state is NORMAL, starve_cnt = 0.
    - If lu_valid deasserts while in FORCE (not expected), return to NORMAL with starve_cnt = 0 and no write.
- Write port, 1-cycle latency:
  - The grant decided in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1.
  - Sources: WB grant = wb_valid && !wb_hold; LU grant = lu_valid && lu_ready.
  - At most one grant per cycle by construction.
  - Writes addressed to register 0 are suppressed (rf_we = 0) but still count as granted.
  - rf_waddr and rf_wdata hold their last values when rf_we = 0.
- Scoreboard:
  - Set: busy[iss_rd] is set on the edge where iss_valid && iss_long && !iss_stall && iss_rd != 0.
  - Clear: busy[lu_rd] is cleared on an LU grant.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is constantly 0.
- iss_stall = iss_valid && ((iss_use_rs1 && busy[rs1]) || (iss_use_rs2 && busy[rs2]) || busy[rd]).
  - The busy[rd] term is the WAW check and applies to all writing instructions.
  - It uses the registered busy_vec, so a release takes effect one cycle after the LU grant (no same-cycle bypass).
  - Forwarding from the pipeline is not this block's concern.
- Width rules: busy_vec indexing is AW bits; starve_cnt is 4 bits and saturates at STARVE_MAX-1.

Decomposition:
- Package rf_sched_pkg:
  - arbiter state encoding (ARB_NORMAL=1'b0, ARB_FORCE=1'b1);
  - REG_ZERO constant;
  - default widths DW/AW.
- Sub-module reg_scoreboard:
  - busy bit array with set/clear ports and set-wins priority;
  - three combinational read taps (rs1, rs2, rd);
  - bit 0 forced to 0.
- The top level contains the FSM, the starvation counter and the write-port registers.

Test Plan:
- Reset then idle: all outputs 0. Then assert Reset while in FORCE → next cycle state NORMAL, busy_vec=0, rf_we=0.
- Long-op issue and RAW stall:
  - Issue long rd=5 → busy_vec[5]=1 next cycle.
  - Issue with rs1=5 → iss_stall=1.
  - lu_valid rd=5, data=0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; iss_stall drops the cycle after.
- Contention, no starvation (STARVE_MAX=4):
  - wb_valid and lu_valid together for 2 cycles → WB writes twice, lu_ready=0.
  - Then wb_valid=0 → LU written next cycle; starve_cnt=0.
- Starvation (STARVE_MAX=4): wb_valid and lu_valid held continuously →
  - 4 denied cycles, then FORCE with wb_hold=1;
  - LU written (rd=7, 0x12345678);
  - next cycle NORMAL and the held WB write lands.
- Register zero: wb_rd=0 write 0xFFFFFFFF → rf_we stays 0; long issue with rd=0 → busy_vec unchanged, no stall.
- Simultaneous set/clear: LU grant for rd=9 in the same cycle as a new long issue to rd=9 → busy_vec[9] stays 1.
